// File: rtl/md_sched.sv
// HI/LO multiply-divide sequencer: fixed-latency busy window, shadow result, commit to HI/LO.
// Optional MD_SCHED_FLUSH_EN adds a flush input that aborts or suppresses operations.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   input  logic        md_use_d,
   input  logic        hi_sel,
`ifdef MD_SCHED_FLUSH_EN
   input  logic        flush,
`endif
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] md_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [3:0] LP_MUL_N = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_N = 4'(DIV_CYCLES);

   logic        r_busy;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi, r_lo, r_sh_hi, r_sh_lo;
   logic        r_commit;

   logic        w_flush;
   logic        w_is_mul, w_is_div;
   logic [63:0] w_ea, w_eb, w_prod, w_res;
   logic        w_a_neg, w_b_neg, w_bz;
   logic [31:0] w_ua, w_ub, w_den, w_uq, w_ur, w_q, w_r;

`ifdef MD_SCHED_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_is_mul = (md_op == 3'd1) || (md_op == 3'd2);
   assign w_is_div = (md_op == 3'd3) || (md_op == 3'd4);
   assign start    = (w_is_mul || w_is_div) && !r_busy && !w_flush;
   assign busy     = r_busy;
   assign stall_md = md_use_d && (start || r_busy);
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign md_out   = hi_sel ? r_hi : r_lo;

   // Low 64 bits of the extended product are correct for both signed and unsigned.
   assign w_ea   = (md_op == 3'd1) ? {{32{md_a[31]}}, md_a} : {32'd0, md_a};
   assign w_eb   = (md_op == 3'd1) ? {{32{md_b[31]}}, md_b} : {32'd0, md_b};
   assign w_prod = w_ea * w_eb;

   // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign w_a_neg = (md_op == 3'd3) && md_a[31];
   assign w_b_neg = (md_op == 3'd3) && md_b[31];
   assign w_ua    = w_a_neg ? (32'd0 - md_a) : md_a;
   assign w_ub    = w_b_neg ? (32'd0 - md_b) : md_b;
   assign w_bz    = (md_b == 32'd0);
   assign w_den   = w_bz ? 32'd1 : w_ub;
   assign w_uq    = w_ua / w_den;
   assign w_ur    = w_ua % w_den;
   assign w_q     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
   assign w_r     = w_a_neg ? (32'd0 - w_ur) : w_ur;

   assign w_res = w_is_mul ? w_prod : {w_r, w_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_cnt    <= 4'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_sh_hi  <= 32'd0;
         r_sh_lo  <= 32'd0;
         r_commit <= 1'b0;
      end else if (r_busy) begin
         if (w_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
         end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_busy <= 1'b0;
               if (r_commit) begin
                  r_hi <= r_sh_hi;
                  r_lo <= r_sh_lo;
               end
            end
         end
      end else if (start) begin
         {r_sh_hi, r_sh_lo} <= w_res;
         r_commit <= w_is_mul || !w_bz;
         r_cnt    <= w_is_mul ? LP_MUL_N : LP_DIV_N;
         r_busy   <= 1'b1;
      end else if (!w_flush) begin
         if (md_op == 3'd5) r_hi <= md_a;
         if (md_op == 3'd6) r_lo <= md_a;
      end
   end
endmodule
